// File: rtl/adder_tb_pkg.sv
// Shared types, constants and golden arithmetic for the adder vector generator.
package adder_tb_pkg;

  localparam int unsigned WIDTH_DEF = 6;
  localparam int unsigned GOLD_W    = 16;

  // Galois tap mask for x^12+x^6+x^4+x+1 (right-shifting form)
  localparam logic [31:0] LFSR_POLY = 32'h0000_0829;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Zero-extended sum; bit w of the result is the carry out of a w-bit add.
  function automatic logic [GOLD_W:0] golden_add(input logic [GOLD_W-1:0] a,
                                                 input logic [GOLD_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/adder_lfsr.sv
// Galois LFSR with load and step enable; a zero seed is replaced by 1.
// next_o is the combinational successor of the current state.
module adder_lfsr #(
  parameter int unsigned N         = 12,
  parameter logic [N-1:0] POLY     = 12'h829
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [N-1:0] seed_i,
  output logic [N-1:0] state_o,
  output logic [N-1:0] next_o
);

  logic [N-1:0] state_q;
  logic [N-1:0] seed_eff;

  // An all-zero state would lock the register, so never load it.
  assign seed_eff = (seed_i == '0) ? N'(1) : seed_i;
  assign next_o   = {1'b0, state_q[N-1:1]} ^ (state_q[0] ? POLY : '0);
  assign state_o  = state_q;

  always_ff @(posedge clk) begin
    if (!reset || load_i) begin
      state_q <= seed_eff;
    end else if (en_i) begin
      state_q <= next_o;
    end
  end

endmodule

// File: rtl/adder_vector_gen.sv
// Self-running operand/golden-result source: exhaustive sweep or LFSR random.
// First vector one cycle after start; outputs registered and held while ready is low.
module adder_vector_gen
  import adder_tb_pkg::*;
#(
  parameter int unsigned          WIDTH     = WIDTH_DEF,
  parameter int unsigned          N_RANDOM  = 1024,
  parameter logic [2*WIDTH-1:0]   LFSR_SEED = 12'hACE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  output logic [WIDTH-1:0]   x,
  output logic [WIDTH-1:0]   y,
  output logic [WIDTH-1:0]   s_exp,
  output logic               ov_exp,
  output logic               valid,
  input  logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   count
);

  localparam int unsigned VW = 2 * WIDTH;
  localparam int unsigned CW = VW + 1;
  localparam logic [CW-1:0] LAST_EXH = CW'((64'(1) << VW) - 64'(1));
  localparam logic [CW-1:0] LAST_RND = CW'(N_RANDOM - 1);

  state_e           state_q;
  logic             mode_q;
  logic [WIDTH-1:0] x_q, y_q, s_q;
  logic             ov_q, valid_q, busy_q, done_q;
  logic [CW-1:0]    count_q;

  logic [VW-1:0]    lfsr_state, lfsr_next;
  logic [VW-1:0]    vec_d;
  logic [WIDTH-1:0] s_d;
  logic             ov_d;
  logic             xfer, is_last;

  assign xfer    = (state_q == RUN) && ready;
  assign is_last = (count_q == (mode_q ? LAST_RND : LAST_EXH));

  // In IDLE the candidate is vector 0 of the requested mode; in RUN it is the successor.
  assign vec_d = (state_q == IDLE) ? (mode ? lfsr_state : '0)
                                   : (mode_q ? lfsr_next : count_q[VW-1:0] + VW'(1));

  assign {ov_d, s_d} = (WIDTH + 1)'(golden_add(GOLD_W'(vec_d[VW-1:WIDTH]),
                                               GOLD_W'(vec_d[WIDTH-1:0])));

  // The LFSR reloads its seed on the way back to IDLE so every random run repeats.
  adder_lfsr #(
    .N    (VW),
    .POLY (LFSR_POLY[VW-1:0])
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load_i  (state_q == DONE),
    .en_i    (xfer && mode_q),
    .seed_i  (LFSR_SEED),
    .state_o (lfsr_state),
    .next_o  (lfsr_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= '0;
      ov_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            mode_q  <= mode;
            count_q <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            x_q     <= vec_d[VW-1:WIDTH];
            y_q     <= vec_d[WIDTH-1:0];
            s_q     <= s_d;
            ov_q    <= ov_d;
          end
        end
        RUN: begin
          if (ready) begin
            count_q <= count_q + CW'(1);
            if (is_last) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              x_q  <= vec_d[VW-1:WIDTH];
              y_q  <= vec_d[WIDTH-1:0];
              s_q  <= s_d;
              ov_q <= ov_d;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign s_exp  = s_q;
  assign ov_exp = ov_q;
  assign valid  = valid_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign count  = count_q;

endmodule

// File: tb/tb_adder_vector_gen.sv
// Directed bench for adder_vector_gen: exhaustive sweep, backpressure, reset, random mode.
module tb_adder_vector_gen;

  localparam int W = 6;

  typedef struct {
    int           idx;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] s;
    logic         ov;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, mode, ready;
  logic [W-1:0] x, y, s_exp;
  logic         ov_exp, valid, busy, done;
  logic [2*W:0] count;

  logic         start_r, mode_r, ready_r;
  logic [W-1:0] x_r, y_r, s_r;
  logic         ov_r, valid_r, busy_r, done_r;
  logic [2*W:0] count_r;

  adder_vector_gen dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .x(x), .y(y), .s_exp(s_exp), .ov_exp(ov_exp),
    .valid(valid), .ready(ready), .busy(busy), .done(done), .count(count)
  );

  adder_vector_gen #(.WIDTH(6), .N_RANDOM(8), .LFSR_SEED(12'h000)) dut_r (
    .clk(clk), .reset(reset), .start(start_r), .mode(mode_r),
    .x(x_r), .y(y_r), .s_exp(s_r), .ov_exp(ov_r),
    .valid(valid_r), .ready(ready_r), .busy(busy_r), .done(done_r), .count(count_r)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  vec_t         tbl[9];
  logic [W-1:0] cap_x[4096];
  logic [W-1:0] cap_y[4096];
  logic [W-1:0] cap_s[4096];
  logic         cap_ov[4096];

  initial begin
    int n, n_done, bad_cnt, bad_sweep, done_bad, last_cyc, done_cyc, found;
    int nr, rdone, rnd_bad;
    logic fin;
    logic [W-1:0] x2, y2, s2;
    logic ov2;

    tbl[0] = '{0,    6'd0,  6'd0,  6'd0,  1'b0};
    tbl[1] = '{1,    6'd0,  6'd1,  6'd1,  1'b0};
    tbl[2] = '{63,   6'd0,  6'd63, 6'd63, 1'b0};
    tbl[3] = '{64,   6'd1,  6'd0,  6'd1,  1'b0};
    tbl[4] = '{100,  6'd1,  6'd36, 6'd37, 1'b0};
    tbl[5] = '{2016, 6'd31, 6'd32, 6'd63, 1'b0};
    tbl[6] = '{2080, 6'd32, 6'd32, 6'd0,  1'b1};
    tbl[7] = '{4033, 6'd63, 6'd1,  6'd0,  1'b1};
    tbl[8] = '{4095, 6'd63, 6'd63, 6'd62, 1'b1};

    reset = 1'b0; start = 1'b0; mode = 1'b0; ready = 1'b1;
    start_r = 1'b0; mode_r = 1'b1; ready_r = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_count", count, 0);
    check("reset_x", x, 0);
    check("reset_valid_r", valid_r, 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_valid", valid, 0);

    // Exhaustive run with ignored start pulses and mode wiggle mid-run
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_valid", valid, 1);
    check("start_busy", busy, 1);
    n = 0; n_done = 0; bad_cnt = 0; done_bad = 0; last_cyc = -100; done_cyc = -100; fin = 1'b0;
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = 1'b0;
      mode  = (cyc >= 500 && cyc < 600);
      if (valid && ready) begin
        if (count !== 13'(n)) bad_cnt++;
        if (n < 4096) begin
          cap_x[n] = x; cap_y[n] = y; cap_s[n] = s_exp; cap_ov[n] = ov_exp;
        end
        n++;
        last_cyc = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        if (busy || valid) done_bad++;
        start = 1'b1;
      end
      if (cyc == 10 || cyc == 2000) start = 1'b1;
      if (n_done > 0 && cyc >= done_cyc + 6) fin = 1'b1;
    end
    check("exh_transfers", n, 4096);
    check("exh_count", count, 4096);
    check("exh_done_pulses", n_done, 1);
    check("exh_done_latency", done_cyc - last_cyc, 1);
    check("exh_done_not_busy", done_bad, 0);
    check("exh_count_tracks", bad_cnt, 0);
    check("exh_idle_valid", valid, 0);
    check("exh_idle_busy", busy, 0);

    bad_sweep = 0;
    for (int i = 0; i < 4096; i++) begin
      if ({cap_x[i], cap_y[i]} !== 12'(i)) bad_sweep++;
      if ({cap_ov[i], cap_s[i]} !== 7'(cap_x[i]) + 7'(cap_y[i])) bad_sweep++;
    end
    check("exh_sweep_bad", bad_sweep, 0);

    for (int k = 0; k < 9; k++) begin
      check($sformatf("vec%0d_x", tbl[k].idx), cap_x[tbl[k].idx], tbl[k].x);
      check($sformatf("vec%0d_y", tbl[k].idx), cap_y[tbl[k].idx], tbl[k].y);
      check($sformatf("vec%0d_s", tbl[k].idx), cap_s[tbl[k].idx], tbl[k].s);
      check($sformatf("vec%0d_ov", tbl[k].idx), cap_ov[tbl[k].idx], tbl[k].ov);
    end

    // Backpressure at vector 5
    start = 1'b1; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 50 && found == 0; c++) begin
      if (valid && count == 13'd5) found = 1;
      else @(negedge clk);
    end
    check("bp_found", found, 1);
    ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_x", x, 0);
      check("bp_hold_y", y, 5);
      check("bp_hold_s", s_exp, 5);
      check("bp_hold_count", count, 5);
      check("bp_hold_valid", valid, 1);
    end
    ready = 1'b1;
    @(negedge clk);
    check("bp_resume_x", x, 0);
    check("bp_resume_y", y, 6);
    check("bp_resume_s", s_exp, 6);
    check("bp_resume_count", count, 6);

    // Reset mid-run at vector 100, then restart from vector 0
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      if (valid && count == 13'd100) found = 1;
      else @(negedge clk);
    end
    check("rst_found", found, 1);
    check("rst_pre_y", y, 36);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_y", y, 0);
    check("rst_s", s_exp, 0);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_valid", valid, 1);
    check("restart_y", y, 0);
    check("restart_count", count, 0);
    @(negedge clk);
    check("restart_next_y", y, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Random mode, zero seed, 8 vectors, one stall cycle
    start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    check("rnd_first_x", x_r, 0);
    check("rnd_first_y", y_r, 1);
    check("rnd_first_s", s_r, 1);
    check("rnd_first_ov", ov_r, 0);
    nr = 0; rdone = 0; rnd_bad = 0;
    x2 = '0; y2 = '0; s2 = '0; ov2 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      ready_r = (c != 3);
      if (valid_r && ready_r) begin
        if ({ov_r, s_r} !== 7'(x_r) + 7'(y_r)) rnd_bad++;
        if (nr == 1) begin
          x2 = x_r; y2 = y_r; s2 = s_r; ov2 = ov_r;
        end
        nr++;
      end
      if (done_r) rdone++;
      @(negedge clk);
    end
    check("rnd_transfers", nr, 8);
    check("rnd_count", count_r, 8);
    check("rnd_done_pulses", rdone, 1);
    check("rnd_sum_bad", rnd_bad, 0);
    check("rnd_vec1_x", x2, 32);
    check("rnd_vec1_y", y2, 41);
    check("rnd_vec1_s", s2, 9);
    check("rnd_vec1_ov", ov2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
